// File: rtl/register_file_mp.sv
// Parametrised multi-port register file: registered read ports, prioritised write ports, sequential bulk clear.
// Optional write-to-read bypass is enabled by defining RF_BYPASS_EN.
module register_file_mp_rd_port #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid
);
    logic [1:0] vld_pipe;

    assign vld_pipe[0] = en;
    assign rvalid      = vld_pipe[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe[1] <= 1'b0;
            rdata       <= '0;
        end else begin
            vld_pipe[1] <= vld_pipe[0];
            if (en) rdata <= din;
        end
    end
endmodule

module register_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1,
    parameter int ZERO_REG   = 0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_RD-1:0]            read_en,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    output logic [NUM_RD-1:0]            rvalid,
    input  logic [NUM_WR-1:0]            write_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wdata,
    input  logic                         clear_req,
    output logic                         clear_busy,
    output logic                         clear_done
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                               state, state_nxt;
    logic [ADDR_WIDTH-1:0]                clr_cnt;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs;
    logic [NUM_WR-1:0]                    we;
    logic [NUM_WR-1:0][ADDR_WIDTH-1:0]    wa;
    logic [NUM_WR-1:0][DATA_WIDTH-1:0]    wd;
    logic [NUM_RD-1:0][ADDR_WIDTH-1:0]    ra;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0]    rdata_lane;
    logic                                 idle;

    assign wa         = waddr;
    assign wd         = wdata;
    assign ra         = raddr;
    assign rdata      = rdata_lane;
    assign idle       = (state == IDLE);
    assign clear_busy = (state == CLEAR);

    // Effective write enables: the clear engine owns the array, and reg 0 may be read-only.
    always_comb begin
        for (int j = 0; j < NUM_WR; j++)
            we[j] = write_en[j] && idle && !((ZERO_REG != 0) && (wa[j] == '0));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clear_req) state_nxt = CLEAR;
            CLEAR:   if (clr_cnt == '1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            clear_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            clear_done <= (state == CLEAR) && (clr_cnt == '1);
            if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // Later ports overwrite earlier ones, so the highest-index port wins on an address clash.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs <= '0;
        end else if (!idle) begin
            regs[clr_cnt] <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++)
                if (we[j]) regs[wa[j]] <= wd[j];
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [DATA_WIDTH-1:0] val;

        always_comb begin
            val = regs[ra[i]];
`ifdef RF_BYPASS_EN
            for (int j = 0; j < NUM_WR; j++)
                if (we[j] && (wa[j] == ra[i])) val = wd[j];
`endif
        end

        register_file_mp_rd_port #(.DATA_WIDTH(DATA_WIDTH)) u_rd (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (read_en[i] && idle),
            .din     (val),
            .rdata   (rdata_lane[i]),
            .rvalid  (rvalid[i])
        );
    end
endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp (2 read ports, 2 write ports); follows RF_BYPASS_EN if defined.
module tb_register_file_mp;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  read_en = '0;
    logic [7:0]  raddr = '0;
    logic [63:0] rdata;
    logic [1:0]  rvalid;
    logic [1:0]  write_en = '0;
    logic [7:0]  waddr = '0;
    logic [63:0] wdata = '0;
    logic        clear_req = 1'b0;
    logic        clear_busy, clear_done;

    logic [1:0]  issued = '0;
    logic        rd_blocked = 1'b0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          n_chk = 0;
    int          n_err = 0;

    register_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(0)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .read_en    (read_en),
        .raddr      (raddr),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .write_en   (write_en),
        .waddr      (waddr),
        .wdata      (wdata),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clear_done (clear_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        read_en    = '0;
        write_en   = '0;
        clear_req  = 1'b0;
        rd_blocked = 1'b0;
    endtask

    task automatic rd(input int p, input logic [3:0] a, input logic [31:0] exp);
        read_en[p]      = 1'b1;
        raddr[p*4 +: 4] = a;
        if (p == 0) q0.push_back(exp);
        else        q1.push_back(exp);
    endtask

    task automatic wr(input int p, input logic [3:0] a, input logic [31:0] d);
        write_en[p]       = 1'b1;
        waddr[p*4 +: 4]   = a;
        wdata[p*32 +: 32] = d;
    endtask

    task automatic fill_all();
        for (int a = 0; a < 16; a += 2) begin
            tick();
            wr(0, 4'(a), 32'hFFFF_FFFF);
            wr(1, 4'(a + 1), 32'hFFFF_FFFF);
        end
        tick();
    endtask

    task automatic read_all_zero();
        for (int a = 0; a < 16; a++) begin
            tick();
            rd(0, 4'(a), 32'h0);
            rd(1, 4'(15 - a), 32'h0);
        end
        tick();
    endtask

    // What the bench itself asked for on the previous edge; reads during clear expect no response.
    always @(posedge clk) issued <= (reset_n && !rd_blocked) ? read_en : 2'b00;

    always @(negedge clk) begin
        logic [31:0] e;
        chk("rvalid0", 64'(rvalid[0]), 64'(issued[0]));
        chk("rvalid1", 64'(rvalid[1]), 64'(issued[1]));
        if (rvalid[0]) begin
            if (q0.size() == 0) chk("rdata0_unexpected", 64'(rdata[31:0]), 64'hX);
            else begin e = q0.pop_front(); chk("rdata0", 64'(rdata[31:0]), 64'(e)); end
        end
        if (rvalid[1]) begin
            if (q1.size() == 0) chk("rdata1_unexpected", 64'(rdata[63:32]), 64'hX);
            else begin e = q1.pop_front(); chk("rdata1", 64'(rdata[63:32]), 64'(e)); end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rdata", rdata, 64'h0);
        chk("rst_rvalid", 64'(rvalid), 64'h0);
        chk("rst_busy", 64'(clear_busy), 64'h0);
        chk("rst_done", 64'(clear_done), 64'h0);
        reset_n = 1'b1;

        read_all_zero();

        // Write then read next cycle; idle port holds its value.
        tick(); wr(0, 4'd5, 32'hDEAD_BEEF);
        tick(); rd(1, 4'd5, 32'hDEAD_BEEF);
        tick();
        tick();
        chk("rdata1_hold", 64'(rdata[63:32]), 64'hDEAD_BEEF);

        // Same-cycle read/write of reg3.
        tick(); wr(0, 4'd3, 32'h1234); rd(0, 4'd3, BYP ? 32'h1234 : 32'h0);
        tick(); rd(0, 4'd3, 32'h1234);
        tick();

        // Write-port priority, plain and through the bypass path.
        tick(); wr(0, 4'd7, 32'hA); wr(1, 4'd7, 32'hB);
        tick(); rd(0, 4'd7, 32'hB);
        tick(); wr(0, 4'd9, 32'h1); wr(1, 4'd9, 32'h2); rd(1, 4'd9, BYP ? 32'h2 : 32'h0);
        tick(); rd(0, 4'd9, 32'h2); rd(1, 4'd5, 32'hDEAD_BEEF);
        tick();

        // Bulk clear: write concurrent with clear_req lands, then gets cleared.
        fill_all();
        rd(0, 4'd0, 32'hFFFF_FFFF); rd(1, 4'd15, 32'hFFFF_FFFF);
        tick(); clear_req = 1'b1; wr(0, 4'd2, 32'h55);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("clr_busy", 64'(clear_busy), 64'h1);
            chk("clr_done_early", 64'(clear_done), 64'h0);
            if (k == 9) begin
                wr(0, 4'd4, 32'h77);
                read_en    = 2'b11;
                rd_blocked = 1'b1;
                clear_req  = 1'b1;
            end
        end
        tick();
        chk("clr_busy_end", 64'(clear_busy), 64'h0);
        chk("clr_done_pulse", 64'(clear_done), 64'h1);
        tick();
        chk("clr_done_drop", 64'(clear_done), 64'h0);
        chk("clr_busy_idle", 64'(clear_busy), 64'h0);
        read_all_zero();

        // Reset during the fifth cycle of a clear.
        fill_all();
        rd(0, 4'd1, 32'hFFFF_FFFF); rd(1, 4'd14, 32'hFFFF_FFFF);
        tick(); clear_req = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        chk("mid_busy", 64'(clear_busy), 64'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_rdata", rdata, 64'h0);
        chk("abort_rvalid", 64'(rvalid), 64'h0);
        chk("abort_busy", 64'(clear_busy), 64'h0);
        chk("abort_done", 64'(clear_done), 64'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("post_abort_busy", 64'(clear_busy), 64'h0);
            chk("post_abort_done", 64'(clear_done), 64'h0);
        end
        read_all_zero();

        tick();
        tick();
        chk("q0_drained", 64'(q0.size()), 64'h0);
        chk("q1_drained", 64'(q1.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
